// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command-line engine.
package sd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_RESP_WAIT,
      ST_RESP_RX,
      ST_TAIL,
      ST_DONE
   } sd_state_t;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_R1   = 2'd1;
   localparam logic [1:0] RESP_R3   = 2'd2;

   localparam logic [6:0]  CRC7_POLY = 7'h09;
   localparam int unsigned FRAME_LEN = 48;
   localparam int unsigned CRC_SPAN  = 40;
   localparam int unsigned NCC_CLKS  = 8;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled cycle, clear has priority.
module sd_crc7
   import sd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_clear,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [6:0] o_crc
);

   logic [6:0] r_crc;
   logic       w_fb;

   assign w_fb  = r_crc[6] ^ i_bit;
   assign o_crc = r_crc;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_crc <= '0;
      end else if (i_en) begin
         r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
      end
   end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: serialises a 48-bit command, optionally receives a
// 48-bit response, then clocks NCC idle cycles before signalling done.
module sd_cmd_engine
   import sd_pkg::*;
#(
   parameter int unsigned CLK_DIV      = 62,
   parameter int unsigned RESP_TIMEOUT = 64
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_start,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic [1:0]  resp_type,
   output logic        busy,
   output logic        done,
   output logic [31:0] resp_arg,
   output logic [5:0]  resp_index,
   output logic        crc_err,
   output logic        timeout,
   output logic        sd_clk,
   output logic        sd_cmd_out,
   output logic        sd_cmd_oe,
   input  logic        sd_cmd_in
);

   localparam int unsigned DIV_W   = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
   localparam int unsigned CNT_MAX = (RESP_TIMEOUT > FRAME_LEN) ? RESP_TIMEOUT : FRAME_LEN;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_SPAN - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(RESP_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] NCC_LAST = CNT_W'(NCC_CLKS);

   sd_state_t         r_state, w_next;
   logic [DIV_W-1:0]  r_div;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_sd_clk;
   logic              r_cmd_out;
   logic              r_oe;
   logic [39:0]       r_hdr;
   logic [1:0]        r_rtype;
   logic [44:0]       r_rx;
   logic [31:0]       r_resp_arg;
   logic [5:0]        r_resp_index;
   logic              r_crc_err;
   logic              r_timeout;

   logic              w_run, w_tick, w_rise, w_fall;
   logic              w_crc_clr, w_crc_en, w_crc_bit;
   logic [6:0]        w_crc;
   logic [45:0]       w_frame;

   assign w_run   = (r_state == ST_SEND) || (r_state == ST_RESP_WAIT) ||
                    (r_state == ST_RESP_RX) || (r_state == ST_TAIL);
   assign w_tick  = w_run && (r_div == DIV_LAST);
   assign w_rise  = w_tick && !r_sd_clk;
   assign w_fall  = w_tick && r_sd_clk;
   assign w_frame = {r_rx, sd_cmd_in};

   sd_crc7 u_crc (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_crc_clr),
      .i_en    (w_crc_en),
      .i_bit   (w_crc_bit),
      .o_crc   (w_crc)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // The CRC block is shared: cleared at accept for TX and again at the
   // end of SEND so it can accumulate the response.
   always_comb begin
      w_next    = r_state;
      busy      = 1'b0;
      done      = 1'b0;
      w_crc_clr = 1'b0;
      w_crc_en  = 1'b0;
      w_crc_bit = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_crc_clr = cmd_start;
            if (cmd_start) w_next = ST_SEND;
         end
         ST_SEND: begin
            busy = 1'b1;
            if (w_rise && (r_cnt <= CRC_LAST)) begin
               w_crc_en  = 1'b1;
               w_crc_bit = r_cmd_out;
            end
            if (w_fall && (r_cnt == LAST_BIT)) begin
               w_crc_clr = 1'b1;
               w_next = ((r_rtype == RESP_R1) || (r_rtype == RESP_R3)) ? ST_RESP_WAIT : ST_TAIL;
            end
         end
         ST_RESP_WAIT: begin
            busy = 1'b1;
            if (w_rise) begin
               if (!sd_cmd_in) begin
                  w_crc_en = 1'b1;
                  w_next   = ST_RESP_RX;
               end else if (r_cnt == TO_LAST) begin
                  w_next = ST_TAIL;
               end
            end
         end
         ST_RESP_RX: begin
            busy = 1'b1;
            if (w_rise && (r_cnt <= CRC_LAST)) begin
               w_crc_en  = 1'b1;
               w_crc_bit = sd_cmd_in;
            end
            if (w_rise && (r_cnt == LAST_BIT)) w_next = ST_TAIL;
         end
         ST_TAIL: begin
            busy = 1'b1;
            if (w_fall && (r_cnt == NCC_LAST)) w_next = ST_DONE;
         end
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_div        <= '0;
         r_cnt        <= '0;
         r_sd_clk     <= 1'b0;
         r_cmd_out    <= 1'b1;
         r_oe         <= 1'b0;
         r_hdr        <= '0;
         r_rtype      <= RESP_NONE;
         r_rx         <= '0;
         r_resp_arg   <= '0;
         r_resp_index <= '0;
         r_crc_err    <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         if (!w_run || w_tick) r_div <= '0;
         else                  r_div <= r_div + 1'b1;

         if (w_tick)      r_sd_clk <= !r_sd_clk;
         else if (!w_run) r_sd_clk <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               r_oe      <= 1'b0;
               r_cmd_out <= 1'b1;
               r_cnt     <= '0;
               if (cmd_start) begin
                  r_hdr        <= {2'b01, cmd_index, cmd_arg};
                  r_rtype      <= resp_type;
                  r_cmd_out    <= 1'b0;
                  r_oe         <= 1'b1;
                  r_resp_arg   <= '0;
                  r_resp_index <= '0;
                  r_crc_err    <= 1'b0;
                  r_timeout    <= 1'b0;
               end
            end
            // r_hdr[39] is the bit on the line; after bit 39 the finished CRC
            // and end bit are loaded into the same shifter.
            ST_SEND: begin
               if (w_fall) begin
                  if (r_cnt == LAST_BIT) begin
                     r_cnt     <= '0;
                     r_oe      <= 1'b0;
                     r_cmd_out <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                     if (r_cnt == CRC_LAST) begin
                        r_hdr     <= {w_crc, 1'b1, 32'h0};
                        r_cmd_out <= w_crc[6];
                     end else begin
                        r_hdr     <= {r_hdr[38:0], 1'b0};
                        r_cmd_out <= r_hdr[38];
                     end
                  end
               end
            end
            ST_RESP_WAIT: begin
               if (w_rise) begin
                  if (!sd_cmd_in) begin
                     r_cnt <= CNT_W'(1);
                     r_rx  <= '0;
                  end else if (r_cnt == TO_LAST) begin
                     r_cnt     <= '0;
                     r_timeout <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            ST_RESP_RX: begin
               if (w_rise) begin
                  r_rx <= {r_rx[43:0], sd_cmd_in};
                  if (r_cnt == LAST_BIT) begin
                     r_cnt        <= '0;
                     r_resp_index <= w_frame[45:40];
                     r_resp_arg   <= w_frame[39:8];
                     r_crc_err    <= ((r_rtype == RESP_R1) && (w_crc != w_frame[7:1])) ||
                                     !w_frame[0];
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            ST_TAIL: begin
               if (w_rise) r_cnt <= r_cnt + 1'b1;
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign sd_clk     = r_sd_clk;
   assign sd_cmd_out = r_cmd_out;
   assign sd_cmd_oe  = r_oe;
   assign resp_arg   = r_resp_arg;
   assign resp_index = r_resp_index;
   assign crc_err    = r_crc_err;
   assign timeout    = r_timeout;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine: stimulus queues expected transactions,
// a monitor checks the captured TX frame, SD clock count and results at done.
module tb_sd_cmd_engine;

   localparam int unsigned DIV  = 2;
   localparam int unsigned TOUT = 64;
   localparam int unsigned HP   = DIV + 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_start = 1'b0;
   logic [5:0]  cmd_index = '0;
   logic [31:0] cmd_arg = '0;
   logic [1:0]  resp_type = '0;
   logic        sd_cmd_in = 1'b1;
   logic        busy, done, crc_err, timeout, sd_clk, sd_cmd_out, sd_cmd_oe;
   logic [31:0] resp_arg;
   logic [5:0]  resp_index;

   always #5 clk = ~clk;

   sd_cmd_engine #(.CLK_DIV(DIV), .RESP_TIMEOUT(TOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_start  (cmd_start),
      .cmd_index  (cmd_index),
      .cmd_arg    (cmd_arg),
      .resp_type  (resp_type),
      .busy       (busy),
      .done       (done),
      .resp_arg   (resp_arg),
      .resp_index (resp_index),
      .crc_err    (crc_err),
      .timeout    (timeout),
      .sd_clk     (sd_clk),
      .sd_cmd_out (sd_cmd_out),
      .sd_cmd_oe  (sd_cmd_oe),
      .sd_cmd_in  (sd_cmd_in)
   );

   typedef struct {
      logic [47:0] tx;
      int unsigned nclk;
      logic [5:0]  idx;
      logic [31:0] arg;
      logic        cerr;
      logic        to;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int unsigned nclk = 0;
   int unsigned tx_bits = 0;
   logic [47:0] tx_sh = '0;
   logic        prev_sd = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // CRC7 as polynomial remainder of M(x)*x^7 divided by x^7+x^3+1.
   function automatic logic [6:0] crc7(input logic [39:0] m);
      logic [46:0] r;
      r = {m, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [47:0] make_resp(input logic [5:0] idx, input logic [31:0] arg);
      return {2'b00, idx, arg, crc7({2'b00, idx, arg}), 1'b1};
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         nclk = 0; tx_bits = 0; tx_sh = '0; prev_sd = 1'b0;
      end else begin
         if (sd_clk && !prev_sd) begin
            nclk++;
            if (sd_cmd_oe) begin
               tx_sh = {tx_sh[46:0], sd_cmd_out};
               tx_bits++;
            end
         end
         prev_sd = sd_clk;
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("tx_frame", 64'(tx_sh), 64'(e.tx));
               chk("tx_bits", 64'(tx_bits), 64'd48);
               chk("sd_clocks", 64'(nclk), 64'(e.nclk));
               chk("resp_index", 64'(resp_index), 64'(e.idx));
               chk("resp_arg", 64'(resp_arg), 64'(e.arg));
               chk("crc_err", 64'(crc_err), 64'(e.cerr));
               chk("timeout", 64'(timeout), 64'(e.to));
               chk("busy_at_done", 64'(busy), 64'd0);
            end
            nclk = 0; tx_bits = 0; tx_sh = '0;
         end
      end
   end

   task automatic wait_fall();
      logic p;
      p = sd_clk;
      for (int k = 0; k < 4000; k++) begin
         @(posedge clk); #1;
         if (p && !sd_clk) return;
         p = sd_clk;
      end
      chk("sd_clk_fall_wait", 64'd1, 64'd0);
   endtask

   task automatic wait_oe_low();
      for (int k = 0; k < 4000; k++) begin
         @(posedge clk); #1;
         if (!sd_cmd_oe) return;
      end
      chk("oe_release_wait", 64'd1, 64'd0);
   endtask

   // mode 0: card keeps the line high; mode 1: card answers with resp after dly clocks
   task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                          input int mode, input int dly, input logic [47:0] resp,
                          input bit mid, output int lat);
      exp_t e;
      time  t0;
      bit   seen;
      bit   has_resp;
      has_resp = (rt == 2'd1) || (rt == 2'd2);
      e.tx   = {2'b01, idx, arg, crc7({2'b01, idx, arg}), 1'b1};
      e.nclk = 56; e.idx = '0; e.arg = '0; e.cerr = 1'b0; e.to = 1'b0;
      if (has_resp && mode == 0) begin
         e.nclk = 48 + TOUT + 8;
         e.to   = 1'b1;
      end else if (has_resp) begin
         e.nclk = 48 + dly + 48 + 8;
         e.idx  = resp[45:40];
         e.arg  = resp[39:8];
         e.cerr = ((rt == 2'd1) && (crc7(resp[47:8]) != resp[7:1])) || !resp[0];
      end
      exp_q.push_back(e);
      lat = -1;
      @(negedge clk);
      cmd_index = idx; cmd_arg = arg; resp_type = rt; cmd_start = 1'b1;
      t0 = $time;
      @(negedge clk);
      cmd_start = 1'b0;
      cmd_index = 6'($urandom); cmd_arg = $urandom; resp_type = 2'($urandom);
      if (mid) begin
         repeat (10) wait_fall();
         @(negedge clk);
         cmd_index = ~idx; cmd_arg = ~arg; cmd_start = 1'b1;
         @(negedge clk);
         cmd_start = 1'b0;
      end
      if (has_resp && mode == 1) begin
         wait_oe_low();
         repeat (dly) wait_fall();
         for (int i = 47; i >= 0; i--) begin
            sd_cmd_in = resp[i];
            wait_fall();
         end
         sd_cmd_in = 1'b1;
      end
      seen = 1'b0;
      for (int k = 0; k < 8000 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) chk("done_wait", 64'd0, 64'd1);
      else lat = int'(($time - t0) / 10);
      @(negedge clk);
   endtask

   initial begin
      int          lat;
      logic [47:0] r;
      logic [5:0]  ri;
      logic [31:0] ra;
      int          mode, dly, var_sel;
      logic [1:0]  rt;
      bit          seen;

      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_oe", 64'(sd_cmd_oe), 64'd0);
      chk("rst_sdclk", 64'(sd_clk), 64'd0);
      chk("rst_cmd_out", 64'(sd_cmd_out), 64'd1);
      chk("rst_resp", {crc_err, timeout, resp_index, resp_arg}, 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // CMD0, no response: frame 0x400000000095, 56 clocks, latency bound
      run_txn(6'd0, 32'h0, 2'd0, 0, 0, '0, 1'b0, lat);
      chk("cmd0_lat_ok", 64'(lat >= 0 && lat <= int'(112 * HP + 3)), 64'd1);

      // CMD8 with good R7 then the same with a corrupted CRC byte
      run_txn(6'd8, 32'h1AA, 2'd1, 1, 2, 48'h08000001AA13, 1'b0, lat);
      repeat (20) @(negedge clk);
      chk("hold_resp_arg", 64'(resp_arg), 64'h1AA);
      chk("hold_resp_index", 64'(resp_index), 64'd8);
      run_txn(6'd8, 32'h1AA, 2'd1, 1, 2, 48'h08000001AA15, 1'b0, lat);

      // no response at all -> timeout
      run_txn(6'd55, 32'h0, 2'd1, 0, 0, '0, 1'b0, lat);
      // start bit on the last allowed sample
      run_txn(6'd41, 32'h40FF8000, 2'd2, 1, TOUT - 1, 48'h3F00FF8000FF, 1'b0, lat);
      // resp_type 3 behaves like no response
      run_txn(6'd7, 32'h12340000, 2'd3, 0, 0, '0, 1'b0, lat);

      // cmd_start mid-SEND is ignored
      run_txn(6'd17, 32'hDEADBEEF, 2'd0, 0, 0, '0, 1'b1, lat);
      repeat (300) @(negedge clk);

      // reset at bit 20 of SEND
      @(negedge clk);
      cmd_index = 6'd2; cmd_arg = 32'hFFFF_FFFF; resp_type = 2'd1; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 4000 && !seen; k++) begin
         @(negedge clk);
         if (tx_bits >= 20) seen = 1'b1;
      end
      chk("reach_bit20", 64'(seen), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_oe", 64'(sd_cmd_oe), 64'd0);
      chk("mid_rst_sdclk", 64'(sd_clk), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_cmd_out", 64'(sd_cmd_out), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      run_txn(6'd0, 32'h0, 2'd0, 0, 0, '0, 1'b0, lat);
      chk("cmd0_after_rst_lat", 64'(lat >= 0 && lat <= int'(112 * HP + 3)), 64'd1);

      // randomized transactions
      for (int n = 0; n < 14; n++) begin
         rt      = 2'($urandom_range(0, 3));
         mode    = ($urandom_range(0, 3) == 0) ? 0 : 1;
         dly     = int'($urandom_range(0, 8));
         var_sel = int'($urandom_range(0, 2));
         ri      = 6'($urandom);
         ra      = $urandom;
         r       = make_resp(ri, ra);
         if (var_sel == 1) r = {2'b00, 14'($urandom), $urandom};
         if (var_sel == 2) r[0] = 1'b0;
         run_txn(6'($urandom), $urandom, rt, mode, dly, r, 1'b0, lat);
      end

      repeat (50) @(negedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
